multiply_seq: RTL and testbench
===============================

MULTIPLY_SEQ -- requirements
Module: multiply_seq

Interface
REQ-001 SHALL have these ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  request; sampled when idle
- multiplicand  input  64  signed operand A
- multiplier  input  64  signed operand B
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- result  output  128  signed product A*B
REQ-002 SHALL use one clock (clk); reset is synchronous and active-high.
REQ-003 SHALL have no parameters; operand widths are fixed at 64/64/128.

Function
REQ-004 SHALL implement states IDLE, CALC and DONE.
REQ-005 In IDLE with start=1, SHALL perform these loads and then enter CALC:
- mcand_reg <= multiplicand
- mreg (65 bits) <= {multiplier, 1'b0}
- product <= 0
- count <= 0
REQ-006 In IDLE with start=0, SHALL hold all registers.
REQ-007 Each CALC cycle SHALL form digit d = -8*mreg[4] + 4*mreg[3] + 2*mreg[2] + mreg[1] + mreg[0], with d in the range -8..+8.
REQ-008 In the same cycle it SHALL update product <= (product + (d*mcand_reg << 64)) >>> 4, using 128-bit signed arithmetic.
REQ-009 In the same cycle it SHALL update mreg <= mreg >>> 4 (arithmetic shift) and count <= count + 1.
REQ-010 SHALL leave CALC for DONE after the step in which count == 15, giving 16 steps in total.
REQ-011 In DONE, SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-012 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-013 result SHALL equal product at all times; the value is valid from the done cycle until the next accepted start.
REQ-014 Latency: with start sampled at edge k, CALC SHALL occupy cycles k+1..k+16 and done SHALL be high in cycle k+17.
REQ-015 A start while busy=1 SHALL be ignored; it SHALL neither restart the operation nor alter the operands.
REQ-016 start held high continuously SHALL begin a new operation in the first IDLE cycle after DONE.
REQ-017 Operand inputs SHALL be sampled only at the accepting edge; later changes SHALL have no effect.
REQ-018 result SHALL be exact for all operand pairs, including -2^63 * -2^63 = 2^126.

Reset
REQ-019 When reset=1 at a clock edge, the next state SHALL be IDLE.
REQ-020 Reset SHALL clear all outputs and internal registers: busy=0, done=0, result=0, count=0, mreg=0, mcand_reg=0.
REQ-021 Reset SHALL override start in the same cycle.
REQ-022 Reset mid-CALC or in DONE SHALL abort the operation with no done pulse.

Configuration
REQ-023 Macro MULT_EARLY_TERM_EN SHALL select early termination, as described in REQ-024 to REQ-026.
REQ-024 When defined: in a CALC cycle where count=c and mreg is all-zeros or all-ones, SHALL apply product <= product >>> (4*(16-c)) and enter DONE.
REQ-025 When defined: in the case of REQ-024, SHALL skip the remaining steps, and result SHALL be bit-identical to the non-terminated result.
REQ-026 When not defined: SHALL always perform 16 CALC cycles, with fixed latency per REQ-014.

Verification
REQ-027 SHALL pass this scenario: A=3, B=5, start at edge k -> done in cycle k+17 (undefined macro), result=15.
REQ-028 SHALL pass this scenario: A=-1, B=0x7FFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001.
REQ-029 SHALL pass this scenario: A=B=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000_0000_0000_0000_0000.
REQ-030 SHALL pass this scenario: start pulse with new operands at k+5 while busy -> ignored; original product delivered at k+17; one done pulse only.
REQ-031 SHALL pass this scenario: reset asserted at k+8 mid-CALC -> next cycle busy=0, result=0, no done pulse; a fresh start then completes correctly.
REQ-032 SHALL pass these scenarios with MULT_EARLY_TERM_EN defined:
- B=0, A=123 -> done at k+2, result=0.
- B=-1, A=7 -> done at k+3, result=-7.

Source files
------------

// File: rtl/multiply_seq.sv
// multiply_seq: sequential signed 64x64 -> 128 multiplier using radix-16
// Booth recoding. It retires four multiplier bits per CALC cycle, so a full
// operation takes 16 CALC cycles followed by a one-cycle DONE pulse.
//
// Optional feature: define MULT_EARLY_TERM_EN to finish early once the
// remaining multiplier bits are pure sign extension (all-zeros or all-ones).
// The default build (macro undefined) always runs all 16 steps.
module multiply_seq (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [63:0]    multiplicand,
    input  logic [63:0]    multiplier,
    output logic           busy,
    output logic           done,
    output logic [127:0]   result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    logic [63:0]    mcand_reg;
    logic [64:0]    mreg_reg;      // {multiplier, 1'b0}, shifted right 4 per step
    logic [127:0]   product_reg;
    logic [3:0]     count_reg;
    logic           busy_reg;
    logic           done_reg;

    // Booth digit and per-step datapath values
    logic [5:0]     digit_pos;     // 4*m3 + 2*m2 + m1 + m0, range 0..8
    logic [5:0]     digit_next;    // two's-complement digit, range -8..+8
    logic [67:0]    pp_next;       // digit * multiplicand, fits in 68 bits
    logic [127:0]   product_next;  // (product + pp<<64) >>> 4
    logic [64:0]    mreg_next;     // mreg >>> 4

`ifdef MULT_EARLY_TERM_EN
    logic           early_term;
    logic [6:0]     et_shift;
    logic [127:0]   et_product;
`endif

    // Radix-16 Booth step. The sum before the shift can reach about 2^130,
    // so the shift is folded into the add: the addend's low 64 bits are zero
    // and cannot carry, which lets product[3:0] be dropped up front and keeps
    // the whole computation exact in 128 bits.
    always_comb begin
        digit_pos    = {3'b000, mreg_reg[3], mreg_reg[2], 1'b0}
                     + {5'b00000, mreg_reg[1]}
                     + {5'b00000, mreg_reg[0]};
        digit_next   = digit_pos - {2'b00, mreg_reg[4], 3'b000};
        pp_next      = $signed({{62{digit_next[5]}}, digit_next})
                     * $signed({{4{mcand_reg[63]}}, mcand_reg});
        product_next = {{4{product_reg[127]}}, product_reg[127:4]}
                     + {pp_next, 60'd0};
        mreg_next    = {{4{mreg_reg[64]}}, mreg_reg[64:4]};
    end

`ifdef MULT_EARLY_TERM_EN
    // Once the unconsumed multiplier bits are pure sign extension every
    // remaining digit is zero, so the outstanding steps reduce to a single
    // arithmetic shift by 4 bits per skipped step (this one included).
    always_comb begin
        early_term = (mreg_reg == {65{1'b0}}) || (mreg_reg == {65{1'b1}});
        et_shift   = 7'd64 - {1'b0, count_reg, 2'b00};
        et_product = $signed(product_reg) >>> et_shift;
    end
`endif

    // Control FSM plus datapath registers; busy and done are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            mcand_reg   <= 64'd0;
            mreg_reg    <= 65'd0;
            product_reg <= 128'd0;
            count_reg   <= 4'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        mcand_reg   <= multiplicand;
                        mreg_reg    <= {multiplier, 1'b0};
                        product_reg <= 128'd0;
                        count_reg   <= 4'd0;
                        busy_reg    <= 1'b1;
                        state_reg   <= CALC;
                    end
                end

                CALC: begin
`ifdef MULT_EARLY_TERM_EN
                    if (early_term) begin
                        product_reg <= et_product;
                        count_reg   <= count_reg + 4'd1;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        product_reg <= product_next;
                        mreg_reg    <= mreg_next;
                        count_reg   <= count_reg + 4'd1;
                        if (count_reg == 4'd15) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
`else
                    product_reg <= product_next;
                    mreg_reg    <= mreg_next;
                    count_reg   <= count_reg + 4'd1;
                    if (count_reg == 4'd15) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
`endif
                end

                DONE: begin
                    // Result stays in product_reg until the next accepted start.
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = product_reg;

endmodule

// File: tb/tb_multiply_seq.sv
// Directed testbench for multiply_seq. Expected products and latencies are
// hand-computed; latencies with MULT_EARLY_TERM_EN defined are selected by
// the same macro.
module tb_multiply_seq;

    logic           clk;
    logic           reset;
    logic           start;
    logic [63:0]    multiplicand;
    logic [63:0]    multiplier;
    logic           busy;
    logic           done;
    logic [127:0]   result;

    int tests_run;
    int tests_failed;

    multiply_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one operation, scramble the operand inputs while it runs, and
    // check latency (cycles after the accepting edge), pulse width and result.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp_res, input int lat_def, input int lat_et);
        int n;
        int exp_lat;
`ifdef MULT_EARLY_TERM_EN
        exp_lat = lat_et;
`else
        exp_lat = lat_def;
`endif
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = 64'h5555_5555_5555_5555;
        multiplier   = 64'hAAAA_AAAA_AAAA_AAAA;
        n = 1;
        check({tag, "_busy_k1"}, {127'd0, busy}, 128'd1);
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(exp_lat));
        check({tag, "_done"}, {127'd0, done}, 128'd1);
        check({tag, "_result"}, result, exp_res);
        tick();
        check({tag, "_done_drop"}, {127'd0, done}, 128'd0);
        check({tag, "_busy_drop"}, {127'd0, busy}, 128'd0);
        check({tag, "_result_hold"}, result, exp_res);
    endtask

    initial begin
        int n;
        int dones;
        int first_done;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = 64'd0;
        multiplier   = 64'd0;
        tick();
        tick();

        // Reset state
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_result", result, 128'd0);

        // Reset overrides a simultaneous start
        start        = 1'b1;
        multiplicand = 64'd3;
        multiplier   = 64'd5;
        tick();
        check("rst_over_start", {127'd0, busy}, 128'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();

        // Directed products
        run_op("p3x5", 64'd3, 64'd5, 128'd15, 17, 3);
        run_op("neg1xmax", 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001, 17, 17);
        run_op("minxmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               128'h4000_0000_0000_0000_0000_0000_0000_0000, 17, 17);
        run_op("a123xb0", 64'd123, 64'd0, 128'd0, 17, 2);
        run_op("a7xbm1", 64'd7, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9, 17, 3);
        run_op("m2xm3", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 128'd6, 17, 3);
        run_op("bigx16", 64'h1234_5678_9ABC_DEF0, 64'h10,
               128'h0000_0000_0000_0001_2345_6789_ABCD_EF00, 17, 4);

        // Start pulse with new operands at k+5 while busy is ignored
        multiplicand = 64'hFFFF_FFFF_FFFF_FFFF;
        multiplier   = 64'h7FFF_FFFF_FFFF_FFFF;
        start        = 1'b1;
        tick();
        start      = 1'b0;
        n          = 1;
        dones      = 0;
        first_done = 0;
        while (n < 25) begin
            if (done) begin
                dones++;
                if (first_done == 0) first_done = n;
            end
            if (n == 5) begin
                start        = 1'b1;
                multiplicand = 64'd9;
                multiplier   = 64'd9;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        check("busy_start_pulses", 128'(dones), 128'd1);
        check("busy_start_latency", 128'(first_done), 128'd17);
        check("busy_start_result", result, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001);

        // Reset asserted mid-CALC aborts with no done pulse
        multiplicand = 64'hFFFF_FFFF_FFFF_FFFF;
        multiplier   = 64'h7FFF_FFFF_FFFF_FFFF;
        start        = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (n < 8) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_done", {127'd0, done}, 128'd0);
        check("abort_result", result, 128'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            tick();
        end
        check("abort_no_done", 128'(dones), 128'd0);
        run_op("after_abort", 64'd3, 64'd5, 128'd15, 17, 3);

        // Start held high: new operation begins in first IDLE cycle after DONE
        multiplicand = 64'd3;
        multiplier   = 64'd5;
        start        = 1'b1;
        tick();
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("hold_done", {127'd0, done}, 128'd1);
        check("hold_result", result, 128'd15);
        tick();
        check("hold_idle_gap", {127'd0, busy}, 128'd0);
        tick();
        check("hold_restart", {127'd0, busy}, 128'd1);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("hold_second_done", {127'd0, done}, 128'd1);
        check("hold_second_result", result, 128'd15);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
